// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in serial-out frame reader.
package piso_pkg;

  typedef enum logic {IDLE, SEND} piso_state_t;

  // Width of the word index. Never narrower than one bit, so a single-word
  // frame still has a legal index port.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/piso_idx_counter.sv
// Word index counter for piso_mem_reader. It loads a start value when a
// frame is captured and steps once per accepted word. tc flags the final
// word of the frame. After the final transfer the counter returns to 0.
// Direction is selected at build time: with PISO_REVERSE_EN defined it
// counts down from NINPUTS-1 to 0; otherwise it counts up from 0.
module piso_idx_counter #(
  parameter int NINPUTS = 4,
  parameter int IW      = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          en,
  output logic [IW-1:0] idx,
  output logic          tc
);

`ifdef PISO_REVERSE_EN
  localparam logic [IW-1:0] START = IW'(NINPUTS - 1);
  localparam logic [IW-1:0] TERM  = '0;
`else
  localparam logic [IW-1:0] START = '0;
  localparam logic [IW-1:0] TERM  = IW'(NINPUTS - 1);
`endif

  assign tc = (idx == TERM);

  // idx: load on capture, step on transfer, return to 0 after the last word
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
    end else if (load) begin
      idx <= START;
    end else if (en) begin
      if (tc) begin
        idx <= '0;
      end else begin
`ifdef PISO_REVERSE_EN
        idx <= idx - IW'(1);
`else
        idx <= idx + IW'(1);
`endif
      end
    end
  end

endmodule

// File: rtl/piso_mem_reader.sv
// Parallel-in serial-out frame reader. It captures NINPUTS words in one
// cycle. It then streams them out one word per valid/ready transfer.
// The optional macro PISO_REVERSE_EN emits the words highest index first.
// out_idx always reports the true buffer index.
module piso_mem_reader
  import piso_pkg::*;
#(
  parameter int IWIDTH  = 8,
  parameter int NINPUTS = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [IWIDTH-1:0]                 in [NINPUTS-1:0],
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [IWIDTH-1:0]                 out,
  output logic [piso_pkg::idx_w(NINPUTS)-1:0] out_idx,
  output logic                              out_last,
  output logic                              busy
);

  localparam int IW = idx_w(NINPUTS);

  piso_state_t       state;
  logic [IWIDTH-1:0] word_buf [NINPUTS-1:0];
  logic [IW-1:0]     idx;
  logic              tc;
  logic              capture;
  logic              xfer;

  assign in_ready  = (state == IDLE) && !rst;
  assign capture   = in_valid && in_ready;
  assign out_valid = (state == SEND);
  assign busy      = (state == SEND);
  assign xfer      = out_valid && out_ready;
  assign out       = (state == SEND) ? word_buf[idx] : '0;
  assign out_idx   = idx;
  assign out_last  = (state == SEND) && tc;

  piso_idx_counter #(
    .NINPUTS (NINPUTS),
    .IW      (IW)
  ) u_idx (
    .clk  (clk),
    .rst  (rst),
    .load (capture),
    .en   (xfer),
    .idx  (idx),
    .tc   (tc)
  );

  // Frame FSM: capture the whole bank in IDLE, then hold it until the last word leaves
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      word_buf <= '{default: '0};
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            word_buf <= in;
            state    <= SEND;
          end
        end
        SEND: begin
          if (out_ready && tc) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_mem_reader.sv
// Self-checking bench for piso_mem_reader (IWIDTH=8, NINPUTS=4, plus a
// NINPUTS=1 instance). It handles both word orders (PISO_REVERSE_EN).
module tb_piso_mem_reader;

  localparam int N = 4;
`ifdef PISO_REVERSE_EN
  localparam bit REV = 1'b1;
`else
  localparam bit REV = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] din [N-1:0];
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;
  logic [1:0] out_idx;
  logic       out_last;
  logic       busy;

  logic       s_in_valid;
  logic       s_in_ready;
  logic [7:0] s_din [0:0];
  logic       s_out_valid;
  logic       s_out_ready;
  logic [7:0] s_out;
  logic [0:0] s_out_idx;
  logic       s_out_last;
  logic       s_busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  piso_mem_reader #(.IWIDTH(8), .NINPUTS(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in(din),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .out_idx(out_idx),
    .out_last(out_last), .busy(busy)
  );

  piso_mem_reader #(.IWIDTH(8), .NINPUTS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in(s_din),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out(s_out), .out_idx(s_out_idx),
    .out_last(s_out_last), .busy(s_busy)
  );

  // Reference model: a queue of the words still owed downstream
  typedef struct {
    int w;
    int i;
    bit l;
  } ent_t;
  ent_t q[$];

  function automatic int seq2idx(input int pos);
    return REV ? (N - 1 - pos) : pos;
  endfunction

  task automatic model_edge();
    ent_t e;
    if (rst) begin
      q.delete();
    end else if (q.size() > 0) begin
      if (out_ready) void'(q.pop_front());
    end else if (in_valid) begin
      for (int k = 0; k < N; k++) begin
        e.i = seq2idx(k);
        e.w = int'(din[e.i]);
        e.l = (k == N - 1);
        q.push_back(e);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_model(input string tag);
    bit sending;
    sending = (q.size() > 0);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(!sending && !rst));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(sending));
    chk({tag, ".busy"}, 32'(busy), 32'(sending));
    if (sending) begin
      chk({tag, ".out"}, 32'(out), 32'(q[0].w));
      chk({tag, ".out_idx"}, 32'(out_idx), 32'(q[0].i));
      chk({tag, ".out_last"}, 32'(out_last), 32'(q[0].l));
    end
  endtask

  task automatic set_frame(input logic [7:0] w0, input logic [7:0] w1,
                           input logic [7:0] w2, input logic [7:0] w3);
    din[0] = w0; din[1] = w1; din[2] = w2; din[3] = w3;
  endtask

  // Directed vector record: pos is the position in the outgoing sequence (-1 = idle)
  typedef struct {
    bit rst;
    bit iv;
    bit ordy;
    int pos;
  } vec_t;

  vec_t vt [14];
  logic [7:0] frame_a [N];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int p;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    set_frame(8'h00, 8'h00, 8'h00, 8'h00);
    s_in_valid = 1'b0; s_out_ready = 1'b0; s_din[0] = 8'h00;
    frame_a[0] = 8'hAA; frame_a[1] = 8'hBB; frame_a[2] = 8'hCC; frame_a[3] = 8'hDD;

    // Basic stream then 3-cycle backpressure on the second word
    vt[0]  = '{1, 0, 0, -1};
    vt[1]  = '{0, 1, 1, 0};
    vt[2]  = '{0, 0, 1, 1};
    vt[3]  = '{0, 0, 1, 2};
    vt[4]  = '{0, 0, 1, 3};
    vt[5]  = '{0, 0, 1, -1};
    vt[6]  = '{0, 1, 0, 0};
    vt[7]  = '{0, 0, 1, 1};
    vt[8]  = '{0, 0, 0, 1};
    vt[9]  = '{0, 0, 0, 1};
    vt[10] = '{0, 0, 0, 1};
    vt[11] = '{0, 0, 1, 2};
    vt[12] = '{0, 0, 1, 3};
    vt[13] = '{0, 0, 1, -1};

    set_frame(frame_a[0], frame_a[1], frame_a[2], frame_a[3]);
    for (int r = 0; r < 14; r++) begin
      rst = vt[r].rst; in_valid = vt[r].iv; out_ready = vt[r].ordy;
      cycle();
      chk($sformatf("vec%0d.out_valid", r), 32'(out_valid), 32'(vt[r].pos >= 0));
      chk($sformatf("vec%0d.busy", r), 32'(busy), 32'(vt[r].pos >= 0));
      chk($sformatf("vec%0d.in_ready", r), 32'(in_ready), 32'(vt[r].pos < 0 && !vt[r].rst));
      if (vt[r].pos >= 0) begin
        p = seq2idx(vt[r].pos);
        chk($sformatf("vec%0d.out", r), 32'(out), 32'(frame_a[p]));
        chk($sformatf("vec%0d.out_idx", r), 32'(out_idx), 32'(p));
        chk($sformatf("vec%0d.out_last", r), 32'(out_last), 32'(vt[r].pos == N - 1));
      end else if (vt[r].rst) begin
        chk("reset.out", 32'(out), 32'h0);
        chk("reset.out_idx", 32'(out_idx), 32'h0);
        chk("reset.out_last", 32'(out_last), 32'h0);
        chk("reset.s_out_valid", 32'(s_out_valid), 32'h0);
        chk("reset.s_in_ready", 32'(s_in_ready), 32'h0);
      end
    end
    in_valid = 1'b0;

    // Input held valid during SEND: frame 1 unchanged, frame 2 after one idle cycle
    in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    check_model("send_in");
    set_frame(8'h11, 8'h22, 8'h33, 8'h44);
    for (int c = 0; c < 11; c++) begin
      cycle();
      check_model("send_in");
    end
    in_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      cycle();
      check_model("drain");
    end

    // Reset mid-frame after two words
    set_frame(8'hAA, 8'hBB, 8'hCC, 8'hDD);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    check_model("midrst");
    cycle();
    check_model("midrst");
    cycle();
    check_model("midrst");
    rst = 1'b1;
    cycle();
    chk("midrst.out_valid", 32'(out_valid), 32'h0);
    chk("midrst.busy", 32'(busy), 32'h0);
    chk("midrst.out", 32'(out), 32'h0);
    chk("midrst.out_idx", 32'(out_idx), 32'h0);
    rst = 1'b0;
    #1;
    chk("midrst.in_ready", 32'(in_ready), 32'h1);
    set_frame(8'h01, 8'h02, 8'h03, 8'h04);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("midrst.new_first", 32'(out), REV ? 32'h04 : 32'h01);
    for (int c = 0; c < 6; c++) begin
      cycle();
      check_model("midrst_new");
    end

    // Randomised traffic against the queue model
    for (int c = 0; c < 600; c++) begin
      rst       = ($urandom_range(0, 59) == 0);
      in_valid  = $urandom_range(0, 1);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++) din[k] = 8'($urandom);
      cycle();
      check_model("rand");
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) cycle();

    // Single-word instance
    s_din[0] = 8'h5A; s_in_valid = 1'b1; s_out_ready = 1'b0;
    cycle();
    s_in_valid = 1'b0; s_din[0] = 8'hFF;
    chk("n1.out_valid", 32'(s_out_valid), 32'h1);
    chk("n1.out", 32'(s_out), 32'h5A);
    chk("n1.out_last", 32'(s_out_last), 32'h1);
    chk("n1.out_idx", 32'(s_out_idx), 32'h0);
    chk("n1.in_ready", 32'(s_in_ready), 32'h0);
    cycle();
    chk("n1.stall_valid", 32'(s_out_valid), 32'h1);
    chk("n1.stall_out", 32'(s_out), 32'h5A);
    s_out_ready = 1'b1;
    cycle();
    chk("n1.idle_valid", 32'(s_out_valid), 32'h0);
    chk("n1.idle_busy", 32'(s_busy), 32'h0);
    chk("n1.idle_in_ready", 32'(s_in_ready), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
